// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache: 8 lines of 8 16-bit words,
// single-word CPU port on one side, whole-line physical memory port on the other.
module l1_cache (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;
  logic [8:0]   tagArray_q  [8];
  logic [127:0] dataArray_q [8];

  logic [8:0]   reqTag;
  logic [2:0]   reqIndex;
  logic [2:0]   reqWord;
  logic [8:0]   storedTag;
  logic [127:0] indexedLine;
  logic         hit;
  logic         request;
  logic         writeHit;
  logic         fillDone;
  logic         unusedAddrBit;

  assign reqTag        = mem_address[15:7];
  assign reqIndex      = mem_address[6:4];
  assign reqWord       = mem_address[3:1];
  assign unusedAddrBit = mem_address[0];

  assign storedTag   = tagArray_q[reqIndex];
  assign indexedLine = dataArray_q[reqIndex];
  assign hit         = valid_q[reqIndex] && (storedTag == reqTag);
  assign request     = mem_read || mem_write;

  assign mem_rdata  = indexedLine[{reqWord, 4'b0000} +: 16];
  assign pmem_wdata = indexedLine;

  // Outputs are purely a function of state and the held request, so reset
  // (which forces IDLE and clears valid) drops every strobe immediately.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    writeHit     = 1'b0;
    fillDone     = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              writeHit = 1'b1;
              if (|mem_byte_enable) begin
                dirty_d[reqIndex] = 1'b1;
              end
            end
          end else if (valid_q[reqIndex] && dirty_q[reqIndex]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {storedTag, reqIndex, 4'b0000};
        if (pmem_resp) begin
          dirty_d[reqIndex] = 1'b0;
          state_d           = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {reqTag, reqIndex, 4'b0000};
        if (pmem_resp) begin
          fillDone          = 1'b1;
          valid_d[reqIndex] = 1'b1;
          dirty_d[reqIndex] = 1'b0;
          state_d           = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; fills and write hits only occur
  // out of FILL/IDLE with a valid line, both impossible while reset holds.
  always_ff @(posedge clk) begin
    if (fillDone) begin
      dataArray_q[reqIndex] <= pmem_rdata;
      tagArray_q[reqIndex]  <= reqTag;
    end else if (writeHit) begin
      if (mem_byte_enable[0]) begin
        dataArray_q[reqIndex][{reqWord, 4'b0000} +: 8] <= mem_wdata[7:0];
      end
      if (mem_byte_enable[1]) begin
        dataArray_q[reqIndex][{reqWord, 4'b1000} +: 8] <= mem_wdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: a flat word-addressed view of memory plus a
// per-index tag/valid/dirty model predicts data, writebacks and fills.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
  );

  // backing = physical memory contents; shadow = what the CPU must observe.
  logic [127:0] backing [4096];
  logic [15:0]  shadow  [32768];
  bit   [8:0]   mTag    [8];
  bit           mValid  [8];
  bit           mDirty  [8];

  int           assertCount = 0;
  int           failCount   = 0;
  logic [127:0] lastWbData;
  logic [15:0]  lastWbAddr;
  logic [15:0]  lastReadData;
  int           lastWbCycles;
  int           lastFillCycles;

  task automatic checkOutput(input string name, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  function automatic logic [127:0] shadowLine(input logic [11:0] lineNum);
    logic [127:0] line;
    for (int w = 0; w < 8; w++) begin
      line[16*w +: 16] = shadow[{lineNum, 3'(w)}];
    end
    return line;
  endfunction

  task automatic loadLine(input logic [11:0] lineNum, input logic [127:0] data);
    backing[lineNum] = data;
    for (int w = 0; w < 8; w++) begin
      shadow[{lineNum, 3'(w)}] = data[16*w +: 16];
    end
  endtask

  function automatic logic [127:0] randomLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reset discards the cache, so the visible memory reverts to physical memory.
  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    for (int l = 0; l < 4096; l++) begin
      loadLine(12'(l), backing[l]);
    end
  endtask

  task automatic resetDut();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetMemResp", mem_resp, 1'b0);
    checkOutput("resetPmemRead", pmem_read, 1'b0);
    checkOutput("resetPmemWrite", pmem_write, 1'b0);
    checkOutput("resetPmemAddr", pmem_address, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic pmemPulse();
    pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = randomLine();
  endtask

  task automatic applyStimulus(input bit isWrite, input bit both, input logic [15:0] addr,
                               input logic [15:0] data, input logic [1:0] mask);
    logic [2:0]  idx;
    logic [8:0]  tag;
    logic [15:0] w;
    bit          expectHit;
    bit          expectWb;
    bit          done;
    int          wbDelay;
    int          fillDelay;
    int          wbCycles;
    int          fillCycles;
    int          idleCycles;
    idx       = addr[6:4];
    tag       = addr[15:7];
    expectHit = mValid[idx] && (mTag[idx] == tag);
    expectWb  = !expectHit && mValid[idx] && mDirty[idx];
    wbDelay   = $urandom_range(1, 3);
    fillDelay = $urandom_range(1, 3);
    wbCycles   = 0;
    fillCycles = 0;
    idleCycles = 0;
    done       = 1'b0;
    @(posedge clk);
    #1;
    mem_read        = !isWrite || both;
    mem_write       = isWrite;
    mem_address     = addr;
    mem_wdata       = data;
    mem_byte_enable = mask;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        checkOutput("respExclusive", {mem_resp, pmem_read & pmem_write}, 2'b00);
      end
      if (mem_resp) begin
        done = 1'b1;
        if (!isWrite) begin
          lastReadData = mem_rdata;
          checkOutput("readData", mem_rdata, shadow[addr[15:1]]);
        end
      end else if (pmem_write) begin
        wbCycles++;
        if (wbCycles == 1) begin
          lastWbData = pmem_wdata;
          lastWbAddr = pmem_address;
          checkOutput("wbAddress", pmem_address, {mTag[idx], idx, 4'h0});
          checkOutput("wbData", pmem_wdata, shadowLine({mTag[idx], idx}));
        end
        if (wbCycles == wbDelay) begin
          backing[pmem_address[15:4]] = pmem_wdata;
          pmemPulse();
        end
      end else if (pmem_read) begin
        fillCycles++;
        if (fillCycles == 1) begin
          checkOutput("fillAddress", pmem_address, {tag, idx, 4'h0});
        end
        if (fillCycles == fillDelay) begin
          pmem_rdata = backing[{tag, idx}];
          pmemPulse();
        end
      end else begin
        idleCycles++;
      end
    end
    checkOutput("respSeen", done, 1'b1);
    checkOutput("writebackCycles", wbCycles, expectWb ? wbDelay : 0);
    checkOutput("fillCycles", fillCycles, expectHit ? 0 : fillDelay);
    checkOutput("idleMissCycles", idleCycles, expectHit ? 0 : 1);
    lastWbCycles   = wbCycles;
    lastFillCycles = fillCycles;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!expectHit) begin
      mValid[idx] = 1'b1;
      mTag[idx]   = tag;
      mDirty[idx] = 1'b0;
    end
    if (isWrite) begin
      w = shadow[addr[15:1]];
      if (mask[0]) w[7:0]  = data[7:0];
      if (mask[1]) w[15:8] = data[15:8];
      shadow[addr[15:1]] = w;
      if (mask != 2'b00) mDirty[idx] = 1'b1;
    end
  endtask

  task automatic resetMidFill(input logic [15:0] addr);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    mem_read    = 1'b1;
    mem_address = addr;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    checkOutput("fillStarted", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("resetDropsRead", pmem_read, 1'b0);
    checkOutput("resetDropsAddr", pmem_address, 16'h0000);
    checkOutput("resetNoResp", mem_resp, 1'b0);
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] line;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    pmem_resp       = 1'b0;
    pmem_rdata      = 128'h0;
    rst_n           = 1'b0;
    for (int l = 0; l < 4096; l++) begin
      loadLine(12'(l), randomLine());
    end
    line = randomLine();
    line[31:16] = 16'hBEEF;
    loadLine(12'h004, line);
    resetDut();

    applyStimulus(1'b0, 1'b0, 16'h0042, 16'h0000, 2'b00);
    checkOutput("coldReadData", lastReadData, 16'hBEEF);
    checkOutput("coldReadNoWb", lastWbCycles, 0);
    applyStimulus(1'b1, 1'b0, 16'h0042, 16'h1234, 2'b01);
    applyStimulus(1'b0, 1'b0, 16'h0042, 16'h0000, 2'b00);
    checkOutput("mergedByte", lastReadData, 16'hBE34);
    checkOutput("hitNoFill", lastFillCycles, 0);
    applyStimulus(1'b0, 1'b0, 16'h00C2, 16'h0000, 2'b00);
    checkOutput("dirtyEvictAddr", lastWbAddr, 16'h0040);
    checkOutput("dirtyEvictWord1", lastWbData[31:16], 16'hBE34);

    applyStimulus(1'b0, 1'b0, 16'h0080, 16'h0000, 2'b00);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    checkOutput("cleanEvictNoWb", lastWbCycles, 0);

    applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b00);
    applyStimulus(1'b1, 1'b0, 16'h0100, 16'hFFFF, 2'b00);
    applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b00);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    checkOutput("zeroMaskNoWb", lastWbCycles, 0);

    resetMidFill(16'h0200);
    applyStimulus(1'b0, 1'b0, 16'h0200, 16'h0000, 2'b00);
    checkOutput("refillAfterReset", lastFillCycles != 0, 1'b1);

    // A small tag pool keeps hits, dirty evictions and clean evictions all frequent.
    for (int n = 0; n < 400; n++) begin
      bit          isWrite;
      logic [15:0] addr;
      isWrite = 1'($urandom_range(0, 1));
      addr    = {7'd0, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 1'($urandom)};
      applyStimulus(isWrite, isWrite && ($urandom_range(0, 3) == 0), addr,
                    16'($urandom), 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 The block SHALL provide the following ports:
  clk  in  1  sole clock; all state updates on rising edge
  rst_n  in  1  asynchronous active-low reset
  mem_read  in  1  CPU read request, held until mem_resp
  mem_write  in  1  CPU write request, held until mem_resp
  mem_byte_enable  in  2  write byte mask (lc3b_mem_wmask); bit0 = low byte
  mem_address  in  16  CPU byte address (lc3b_word)
  mem_wdata  in  16  CPU write data (lc3b_word)
  mem_resp  out  1  request complete, one-cycle pulse
  mem_rdata  out  16  read data (lc3b_word)
  pmem_read  out  1  line fill request to physical memory
  pmem_write  out  1  line writeback request to physical memory
  pmem_address  out  16  line-aligned physical address, [3:0]=0
  pmem_wdata  out  128  line being written back
  pmem_resp  in  1  physical memory transaction complete
  pmem_rdata  in  128  fill line data
REQ-002 One clock and an asynchronous active-low reset are already decided; no other clock or reset SHALL exist.

Function
REQ-003 Organisation: direct-mapped, write-back, write-allocate; 8 lines x 16 bytes (8 words); per line: 9-bit tag, valid, dirty.
REQ-004 Address split: tag = mem_address[15:7], index = [6:4], word = [3:1]; mem_address[0] ignored.
REQ-005 Hit = valid[index] and tag[index] == address tag.
REQ-006 FSM states: IDLE, WRITEBACK, FILL.
REQ-007 IDLE, no request: mem_resp=0, pmem_read=0, pmem_write=0, state held.
REQ-008 IDLE, read hit: mem_resp=1 combinationally in the same cycle; mem_rdata = addressed word of the indexed line.
REQ-009 IDLE, write hit: mem_resp=1 in the same cycle; at the clock edge the enabled bytes of the addressed word update and dirty[index] sets; mask 2'b00 still responds, changes no data, and sets no dirty bit.
REQ-010 IDLE, miss, line invalid or clean: next state FILL.
REQ-011 IDLE, miss, line valid and dirty: next state WRITEBACK.
REQ-012 WRITEBACK: pmem_write=1; pmem_address={stored tag, index, 4'b0}; pmem_wdata = stored line.
REQ-013 WRITEBACK: held until pmem_resp; on pmem_resp the dirty bit clears and the next state is FILL.
REQ-014 FILL: pmem_read=1; pmem_address={request tag, index, 4'b0}.
REQ-015 FILL: held until pmem_resp; on pmem_resp, line = pmem_rdata, tag written, valid=1, dirty=0, next state IDLE.
REQ-016 After FILL, the still-held request SHALL hit in IDLE on the next cycle, giving miss latency = fill cycles + 1, or writeback + fill + 1 when dirty.
REQ-017 mem_resp SHALL never assert outside IDLE; pmem_read and pmem_write SHALL never assert together.
REQ-018 mem_read and mem_write both high SHALL be treated as a write.
REQ-019 mem_rdata SHALL equal the addressed word of the indexed line in every state; it is meaningful only with mem_resp.
REQ-020 Line byte layout: word w occupies line bits [16w+15:16w].
REQ-021 Other lines SHALL be unaffected by any access.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, all valid=0, all dirty=0, mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0.
REQ-023 Tag and data arrays are not reset.
REQ-024 Reset during WRITEBACK or FILL SHALL abandon the transaction; no partial line or tag update SHALL occur.

Verification
REQ-025 Cold read 0x0042 after reset -> FILL with pmem_address=0x0040; pmem_rdata word1=0xBEEF -> next cycle mem_resp=1, mem_rdata=0xBEEF, no pmem_write.
REQ-026 Write 0x0042, data 0x1234, mask 2'b01 to the line above -> same-cycle mem_resp; read 0x0042 -> 0xBE34, 0 pmem cycles.
REQ-027 Dirty eviction: then read 0x00C2 (same index 4, tag 1) -> WRITEBACK at 0x0040 with pmem_wdata word1=0xBE34, then FILL at 0x00C0, then mem_resp.
REQ-028 Clean eviction: read 0x0080 then 0x0000 with no intervening writes -> FILL only, pmem_write never asserted.
REQ-029 Reset mid-FILL: rst_n low with pmem_read=1 -> pmem_read drops same cycle; subsequent read of that address misses again.
REQ-030 Mask 2'b00 write hit -> mem_resp=1, data unchanged, and the line's next eviction issues no WRITEBACK.
